// File: rtl/cobra_exec_ctrl.sv
// cobra_exec_ctrl: run/step/halt/restart sequencer for a core.
// It drives the core's clock enable and synchronous reset, halts on a PC
// breakpoint, and counts the cycles in which the core was enabled.
module cobra_exec_ctrl #(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             halt_i,
    input  logic             restart_i,
    input  logic             bp_en_i,
    input  logic [31:0]      bp_addr_i,
    input  logic [31:0]      pc_i,
    output logic             core_en_o,
    output logic             core_rst_o,
    output logic [1:0]       state_o,
    output logic             bp_hit_o,
    output logic [CNT_W-1:0] cycles_o
);

    localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    // The counter is loaded with RST_CYCLES-1 and leaves RSTSEQ after
    // reaching zero, giving exactly RST_CYCLES cycles in RSTSEQ.
    localparam logic [RC_W-1:0] RST_LOAD = RC_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HALT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_RSTSEQ = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic              first_run_q, first_run_d;
    logic              bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              bp_match;

    // Breakpoint is masked in the first RUN cycle so that resuming from a
    // breakpoint PC executes that instruction instead of re-halting.
    assign bp_match = (state_q == ST_RUN) && !first_run_q && bp_en_i && (pc_i == bp_addr_i);

    // State register and bookkeeping registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst_i) begin
            state_q     <= ST_RSTSEQ;
            rst_cnt_q   <= RST_LOAD;
            first_run_q <= 1'b0;
            bp_hit_q    <= 1'b0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            first_run_q <= first_run_d;
            bp_hit_q    <= bp_hit_d;
            cycles_q    <= cycles_d;
        end
    end

    // Next-state logic: restart > halt > step > run, breakpoint in RUN.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        if (restart_i) begin
            state_d   = ST_RSTSEQ;
            rst_cnt_d = RST_LOAD;
        end else begin
            case (state_q)
                ST_RSTSEQ: begin
                    if (rst_cnt_q == '0) begin
                        state_d = ST_HALT;
                    end else begin
                        rst_cnt_d = rst_cnt_q - RC_W'(1);
                    end
                end
                ST_HALT: begin
                    if (halt_i) begin
                        state_d = ST_HALT;
                    end else if (step_i) begin
                        state_d = ST_STEP;
                    end else if (run_i) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt_i || bp_match) begin
                        state_d = ST_HALT;
                    end
                end
                ST_STEP: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_RSTSEQ;
                end
            endcase
        end
    end

    // Core-facing outputs; rst_i overrides everything combinationally so a
    // reset mid-RUN or mid-STEP never produces another enable pulse.
    always_comb begin
        core_rst_o = rst_i || (state_q == ST_RSTSEQ);
        core_en_o  = !rst_i && ((state_q == ST_STEP) || ((state_q == ST_RUN) && !bp_match));
    end

    // Breakpoint flag, first-RUN marker and enabled-cycle counter updates.
    always_comb begin
        first_run_d = (state_q == ST_HALT) && (state_d == ST_RUN);
        bp_hit_d    = bp_hit_q;
        cycles_d    = cycles_q;
        if (restart_i) begin
            bp_hit_d = 1'b0;
            cycles_d = '0;
        end else begin
            if (bp_match) begin
                bp_hit_d = 1'b1;
            end else if ((state_q == ST_HALT) && (state_d != ST_HALT)) begin
                bp_hit_d = 1'b0;
            end
            if (core_en_o) begin
                cycles_d = cycles_q + CNT_W'(1);
            end
        end
    end

    assign state_o  = state_q;
    assign bp_hit_o = bp_hit_q;
    assign cycles_o = cycles_q;

endmodule

// File: tb/tb_cobra_exec_ctrl.sv
// Self-checking bench for cobra_exec_ctrl. A small core model advances pc
// by 4 on every enabled cycle; the stimulus pushes the PCs it expects the
// core to execute, and a monitor pops one per observed core_en_o pulse.
module tb_cobra_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        run_i = 1'b0, step_i = 1'b0, halt_i = 1'b0, restart_i = 1'b0;
    logic        bp_en_i = 1'b0;
    logic [31:0] bp_addr_i = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        pc_clr = 1'b1;

    logic        core_en, core_rst, bp_hit;
    logic [1:0]  state;
    logic [31:0] cycles;
    logic        core_en4, core_rst4, bp_hit4;
    logic [1:0]  state4;
    logic [3:0]  cycles4;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_pc_q[$];

    always #5 clk = ~clk;

    cobra_exec_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .step_i(step_i),
        .halt_i(halt_i), .restart_i(restart_i), .bp_en_i(bp_en_i),
        .bp_addr_i(bp_addr_i), .pc_i(pc), .core_en_o(core_en),
        .core_rst_o(core_rst), .state_o(state), .bp_hit_o(bp_hit),
        .cycles_o(cycles)
    );

    // Narrow-counter instance sharing the same stimulus, used for the wrap test.
    cobra_exec_ctrl #(.RST_CYCLES(4), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .step_i(step_i),
        .halt_i(halt_i), .restart_i(restart_i), .bp_en_i(bp_en_i),
        .bp_addr_i(bp_addr_i), .pc_i(pc), .core_en_o(core_en4),
        .core_rst_o(core_rst4), .state_o(state4), .bp_hit_o(bp_hit4),
        .cycles_o(cycles4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core model: the PC advances by one instruction per enabled cycle.
    always @(posedge clk) begin
        if (pc_clr) pc <= 32'h0;
        else if (core_en) pc <= pc + 32'd4;
    end

    // Scoreboard monitor: every enable pulse must match the next expected PC.
    always @(negedge clk) begin
        if (core_en) begin
            if (exp_pc_q.size() == 0) begin
                check("unexpected_pulse", {32'h0, pc}, 64'hFFFF_FFFF);
            end else begin
                check("pulse_pc", {32'h0, pc}, {32'h0, exp_pc_q.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int n, input logic [31:0] start_pc);
        for (int i = 0; i < n; i++) exp_pc_q.push_back(start_pc + 32'(4 * i));
    endtask

    task automatic wait_halt(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (state == 2'd0) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        if (!seen) check({tag, "_timeout"}, {62'h0, state}, 64'h0);
    endtask

    task automatic do_restart();
        restart_i = 1'b1;
        pc_clr    = 1'b1;
        cyc();
        restart_i = 1'b0;
        pc_clr    = 1'b0;
        wait_halt("restart");
    endtask

    initial begin
        int n;

        // Reset sequence: one rst_i cycle, then RST_CYCLES of core_rst_o.
        #2;
        check("rst_core_rst", core_rst, 1);
        check("rst_core_en", core_en, 0);
        cyc();
        rst_i  = 1'b0;
        pc_clr = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (!core_rst) break;
            n++;
            cyc();
        end
        check("rstseq_len", n, 4);
        check("rst_state", state, 0);
        check("rst_cycles", cycles, 0);
        check("rst_bp_hit", bp_hit, 0);

        // Step: three single-cycle pulses, two cycles apart.
        for (int i = 0; i < 3; i++) begin
            exp_pc_q.push_back(32'(4 * i));
            step_i = 1'b1;
            cyc();
            step_i = 1'b0;
            #2;
            check("step_state", state, 2);
            cyc();
            cyc();
        end
        #2;
        check("step_cycles", cycles, 3);
        check("step_state_back", state, 0);

        // Run then halt 10 cycles later: 10 enabled cycles.
        do_restart();
        check("restart_clr_cycles", cycles, 0);
        push_run(10, 32'h0);
        run_i = 1'b1;
        cyc();
        run_i = 1'b0;
        repeat (9) cyc();
        halt_i = 1'b1;
        #2;
        check("halt_cycle_en", core_en, 1);
        cyc();
        halt_i = 1'b0;
        #2;
        check("run_cycles", cycles, 10);
        check("run_halt_state", state, 0);
        check("run_cycles_w4", cycles4, 10);

        // Breakpoint at 0x10, then resume executes 0x10 and clears bp_hit.
        do_restart();
        bp_en_i   = 1'b1;
        bp_addr_i = 32'h10;
        push_run(4, 32'h0);
        run_i = 1'b1;
        cyc();
        run_i = 1'b0;
        repeat (4) cyc();
        #2;
        check("bp_pc", pc, 32'h10);
        check("bp_en_low", core_en, 0);
        cyc();
        #2;
        check("bp_state", state, 0);
        check("bp_hit_set", bp_hit, 1);
        check("bp_cycles", cycles, 4);
        push_run(2, 32'h10);
        run_i = 1'b1;
        cyc();
        run_i = 1'b0;
        #2;
        check("bp_resume_en", core_en, 1);
        check("bp_hit_clr", bp_hit, 0);
        cyc();
        halt_i = 1'b1;
        cyc();
        halt_i = 1'b0;
        #2;
        check("bp_resume_cycles", cycles, 6);
        bp_en_i = 1'b0;

        // Priority: restart beats run; halt beats step.
        restart_i = 1'b1;
        run_i     = 1'b1;
        pc_clr    = 1'b1;
        cyc();
        restart_i = 1'b0;
        run_i     = 1'b0;
        pc_clr    = 1'b0;
        #2;
        check("prio_restart_state", state, 3);
        check("prio_restart_cycles", cycles, 0);
        // Restart inside RSTSEQ reloads the count.
        cyc();
        restart_i = 1'b1;
        cyc();
        restart_i = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (!core_rst) break;
            n++;
            cyc();
        end
        check("rstseq_reload_len", n, 4);
        halt_i = 1'b1;
        step_i = 1'b1;
        cyc();
        halt_i = 1'b0;
        step_i = 1'b0;
        #2;
        check("prio_halt_state", state, 0);
        check("prio_halt_cycles", cycles, 0);

        // Wrap: 17 enabled cycles on the 4-bit counter leaves 1.
        do_restart();
        push_run(17, 32'h0);
        run_i = 1'b1;
        cyc();
        run_i = 1'b0;
        repeat (16) cyc();
        halt_i = 1'b1;
        cyc();
        halt_i = 1'b0;
        #2;
        check("wrap_cycles_w4", cycles4, 1);
        check("wrap_cycles_w32", cycles, 17);

        // Reset mid-RUN aborts with no further enable pulse.
        pc_clr = 1'b1;
        cyc();
        pc_clr = 1'b0;
        push_run(3, 32'h0);
        run_i = 1'b1;
        cyc();
        run_i = 1'b0;
        repeat (3) cyc();
        rst_i = 1'b1;
        #2;
        check("rst_run_en", core_en, 0);
        check("rst_run_core_rst", core_rst, 1);
        cyc();
        rst_i = 1'b0;
        #2;
        check("rst_run_state", state, 3);
        check("rst_run_cycles", cycles, 0);
        wait_halt("rst_run");
        check("rst_run_en_halt", core_en, 0);

        check("sb_drained", exp_pc_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cobra_exec_ctrl.md
COBRA_EXEC_CTRL -- requirements
Module: cobra_exec_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4: number of cycles core_rst_o is held after any reset or restart.
REQ-002 SHALL have parameter CNT_W, default 32: width of the enabled-cycle counter.
REQ-003 SHALL have port clk_i  in  1  single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port run_i  in  1  command: free-run the core.
REQ-006 SHALL have port step_i  in  1  command: execute exactly one core cycle.
REQ-007 SHALL have port halt_i  in  1  command: stop the core.
REQ-008 SHALL have port restart_i  in  1  command: re-run the core reset sequence.
REQ-009 SHALL have port bp_en_i  in  1  breakpoint enable.
REQ-010 SHALL have port bp_addr_i  in  32  breakpoint PC value.
REQ-011 SHALL have port pc_i  in  32  current core program counter.
REQ-012 SHALL have port core_en_o  out  1  clock enable to the core.
REQ-013 SHALL have port core_rst_o  out  1  synchronous reset to the core.
REQ-014 SHALL have port state_o  out  2  encoding: HALT=0, RUN=1, STEP=2, RSTSEQ=3.
REQ-015 SHALL have port bp_hit_o  out  1  sticky flag: halted by breakpoint.
REQ-016 SHALL have port cycles_o  out  CNT_W  count of cycles with core_en_o=1.

Function
REQ-017 SHALL implement a FSM with states RSTSEQ, HALT, RUN, STEP.
REQ-018 RSTSEQ SHALL drive core_rst_o=1 and core_en_o=0 for exactly RST_CYCLES cycles, then enter HALT.
REQ-019 core_rst_o SHALL be 0 in every state except RSTSEQ.
REQ-020 Command priority in every state SHALL be restart_i > halt_i > step_i > run_i; lower-priority commands in the same cycle SHALL be ignored.
REQ-021 restart_i in any state SHALL enter RSTSEQ next cycle, clear cycles_o and bp_hit_o, and reload the RSTSEQ counter; restart_i during RSTSEQ SHALL restart the count.
REQ-022 In RSTSEQ, commands other than restart_i SHALL be ignored.
REQ-023 In HALT, run_i SHALL enter RUN and step_i SHALL enter STEP next cycle; bp_hit_o SHALL clear on the same edge.
REQ-024 core_en_o SHALL be 0 in HALT and RSTSEQ, 1 in STEP, and 1 in RUN unless a breakpoint match occurs that cycle.
REQ-025 Breakpoint match SHALL be combinational: bp_en_i=1 and pc_i==bp_addr_i, evaluated only in RUN.
REQ-026 On a match in RUN, core_en_o SHALL be 0 in that same cycle, the FSM SHALL enter HALT next cycle, and bp_hit_o SHALL be set.
REQ-027 The first RUN cycle after HALT SHALL ignore the breakpoint, so resuming from a breakpoint PC executes that instruction.
REQ-028 STEP SHALL last exactly one cycle, ignore the breakpoint, and return to HALT unless a higher-priority command redirects it.
REQ-029 halt_i in RUN SHALL enter HALT next cycle; core_en_o SHALL remain 1 in the cycle halt_i is sampled, unless a breakpoint matches.
REQ-030 run_i in RUN and step_i or run_i in STEP SHALL have no effect.
REQ-031 cycles_o SHALL increment by 1 on every edge where core_en_o=1, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-032 state_o SHALL be registered and equal the current FSM state.

Reset
REQ-033 rst_i=1 SHALL set, on the next edge, state=RSTSEQ with the counter loaded, cycles_o=0, and bp_hit_o=0.
REQ-034 While rst_i=1, outputs SHALL be core_rst_o=1 and core_en_o=0; rst_i SHALL override all commands.
REQ-035 Reset asserted mid-RUN or mid-STEP SHALL abort without a further core_en_o pulse.

Verification
REQ-036 Reset sequence: rst_i high for 1 cycle, then low -> core_rst_o=1 for 4 cycles, state_o=0 afterward, cycles_o=0.
REQ-037 Step: in HALT, pulse step_i 3 times, spaced 2 cycles apart -> exactly 3 single-cycle core_en_o pulses, cycles_o=3, state_o returns to 0.
REQ-038 Run/halt: run_i pulse, then halt_i 10 cycles later -> core_en_o high for 10 cycles, cycles_o=10.
REQ-039 Breakpoint: bp_en_i=1, bp_addr_i=0x10, pc_i advancing 4 per enabled cycle from 0 -> core_en_o=0 when pc_i=0x10, bp_hit_o=1, state_o=0; run_i again -> instruction at 0x10 is executed and bp_hit_o clears.
REQ-040 Priority: restart_i and run_i in the same HALT cycle -> RSTSEQ; halt_i and step_i together in HALT -> stays HALT with no pulse.
REQ-041 Wrap: CNT_W=4, run for 17 enabled cycles -> cycles_o=1.
